muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage: takes the two source operands from the register file read ports, computes the result over multiple cycles, and hands the result plus destination index to writeback, which drives the register file write port. Pipeline control stalls on `busy`. Writeback consumes `result`/`rd_out` when `done` pulses.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 resets the block.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  WIDTH  rs1 value (multiplicand/dividend).
- `op_b`  in  WIDTH  rs2 value (multiplier/divisor).
- `rd_in`  in  5  destination register index.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse; result/rd_out valid.
- `result`  out  WIDTH  result; holds until the next done.
- `rd_out`  out  5  captured rd_in; holds with result.

## Operation
- States: IDLE, PREP, RUN, FINISH.
- IDLE: `start`=1 captures funct3, operands and rd_in, then goes to PREP. `start` in any other state is ignored.
- PREP: compute operand magnitudes and result sign per op.
  - MULHSU: op_a is signed, op_b unsigned.
  - Load the 5-bit step counter with 31.
  - Fast-path cases go directly to FINISH. Otherwise go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Exit to FINISH after the counter reaches 0, which is 32 steps.
- FINISH:
  - Apply sign correction and select the low word (MUL) or high word (MULH*) of the 64-bit product, or the quotient/remainder.
  - Register `result` and `rd_out` and assert `done`.
  - Return to IDLE.
- Fast paths:
  - Divisor 0: DIV/DIVU gives 0xFFFFFFFF; REM/REMU gives the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Signs: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend. Rounding is toward zero.
- Reset mid-operation aborts to IDLE. No done is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `rd_out`=0, state IDLE.
- Start sampled at edge E0:
  - `busy`=1 after E0.
  - Normal path: `done`=1 in the cycle after E33 (PREP + 32 RUN + FINISH), i.e. 34 cycles.
  - Fast path: `done`=1 in the cycle after E1, i.e. 2 cycles.
- `busy` is low in the cycle `done` is high. A new `start` is accepted in that same cycle, so back-to-back operations are possible.
- `done` is never high for more than one consecutive cycle.

## Configuration
- `MULDIV_DIV_EN` defined: the full divider datapath and DIV/DIVU/REM/REMU behave as above.
- Not defined: no divider logic is built. funct3 4–7 take the fast path and return `result`=0 with `done` after 2 cycles. Multiply behaviour is unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum;
  - the funct3 localparams (FN_MUL … FN_REMU);
  - constants ALL_ONES and INT_MIN.
- Single module, no sub-modules. The shared 33-bit adder/subtractor is muxed between multiply and divide.

## Test plan
- MUL 12×6 → `result`=72, `done` exactly 34 cycles after start, `rd_out`=rd_in.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
- MULHU same operands → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 20/6 → 3 and REM → 2.
- DIV −20/6 → 0xFFFFFFFD and REM → 0xFFFFFFFE.
- DIVU 20/0 → 0xFFFFFFFF and REMU 20/0 → 20, `done` at 2 cycles.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- start pulsed again while busy: ignored, first result unaffected.
- reset=0 at RUN cycle 10: all outputs 0 and no done pulse. A new MUL 6×20 after release gives 120.
- Back-to-back: start held high in the done cycle → second op accepted, `done` 34 cycles later.
- Without `MULDIV_DIV_EN`: DIV 20/6 → 0 after 2 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // funct3 encodings of the M extension
  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // Step counter preload: 32 iterations count 31 down to 0.
  localparam logic [4:0] STEP_LAST = 5'd31;

  // Two's complement negate when neg is set.
  function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between execute control and the muldiv unit.
// Latency: n/a (wires only).
// Backpressure: none; requester holds off while busy, result is taken on done.
// Ports: start/funct3/op_a/op_b/rd_in (request), busy/done/result/rd_out (response).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       rd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add / restoring divide).
// Latency: done 34 cycles after start is sampled; divide fast paths finish in 2.
// Backpressure: start is only taken in IDLE or the done cycle; busy stalls the pipe.
// Ports: clk, reset (async, active-low), bus (muldiv_if.slave).
// Build option: MULDIV_DIV_EN adds the divider; without it funct3 4-7 return 0 in 2 cycles.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_t           state, state_nxt;
  logic             busy_c, done_c;

  logic [2:0]       fn_q;
  logic [4:0]       rd_q;
  logic [4:0]       cnt_q;
  logic [4:0]       rd_out_q;
  logic [WIDTH-1:0] hi_q;      // product high word / partial remainder
  logic [WIDTH-1:0] lo_q;      // multiplier+product low word / dividend+quotient
  logic [WIDTH-1:0] opnd_q;    // multiplicand / divisor
  logic [WIDTH-1:0] result_q;
  logic             neg_main_q;  // negate product or quotient at the end
`ifdef MULDIV_DIV_EN
  logic             neg_rem_q;   // remainder follows dividend sign
`endif

  // ---------------------------------------------------------------
  // PREP: operand signedness per op. During PREP lo_q/opnd_q still
  // hold the raw op_a/op_b captured at start.
  // ---------------------------------------------------------------
  logic             sgn_a, sgn_b, is_div, fast;
  logic [WIDTH-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (fn_q)
      FN_MULH, FN_DIV, FN_REM: begin
        sgn_a = lo_q[WIDTH-1];
        sgn_b = opnd_q[WIDTH-1];
      end
      FN_MULHSU: sgn_a = lo_q[WIDTH-1];
      // low word of the product is sign-agnostic, so MUL runs unsigned
      FN_MUL, FN_MULHU, FN_DIVU, FN_REMU: ;
      default: ;
    endcase
  end

  assign is_div = fn_q[2];
  assign mag_a  = negate_if(sgn_a, lo_q);
  assign mag_b  = negate_if(sgn_b, opnd_q);

`ifdef MULDIV_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = (opnd_q == '0);
  assign div_ovf  = ((fn_q == FN_DIV) || (fn_q == FN_REM)) &&
                    (lo_q == INT_MIN) && (opnd_q == ALL_ONES);
  assign fast     = is_div && (div_zero || div_ovf);
  // fn_q[1] separates REM/REMU from DIV/DIVU
  assign fast_res = div_zero ? (fn_q[1] ? lo_q : ALL_ONES)
                             : (fn_q[1] ? '0   : INT_MIN);
`else
  assign fast     = is_div;
  assign fast_res = '0;
`endif

  // ---------------------------------------------------------------
  // Shared 33-bit adder/subtractor.
  // Multiply: {0,hi} + (lo[0] ? mcand : 0), then the 65-bit {sum,lo}
  // shifts right by one.
  // Divide: {hi,lo[msb]} - {0,divisor}; bit WIDTH of the result is the
  // borrow, since the partial remainder is always below the divisor.
  // ---------------------------------------------------------------
  logic             add_sub;
  logic [WIDTH:0]   add_x, add_y, add_sum;

`ifdef MULDIV_DIV_EN
  assign add_sub = is_div;
  assign add_x   = is_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
  assign add_y   = (is_div || lo_q[0]) ? {1'b0, opnd_q} : '0;
`else
  assign add_sub = 1'b0;
  assign add_x   = {1'b0, hi_q};
  assign add_y   = lo_q[0] ? {1'b0, opnd_q} : '0;
`endif

  assign add_sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};

  // One iteration plus the end-of-op result. On the last RUN cycle the
  // result is formed from the step outputs so it lands in result_q on
  // the same edge that enters FINISH.
  logic [WIDTH-1:0]   hi_step, lo_step, fin_res;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    hi_step = add_sum[WIDTH:1];
    lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // borrow: trial subtract failed, keep the shifted remainder
      hi_step = add_sum[WIDTH] ? add_x[WIDTH-1:0] : add_sum[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
    end
`endif
    prod     = {hi_step, lo_step};
    prod_fix = neg_main_q ? (~prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod;
    fin_res  = (fn_q == FN_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      fin_res = fn_q[1] ? negate_if(neg_rem_q, hi_step) : negate_if(neg_main_q, lo_step);
    end
`endif
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_PREP;
      end
      ST_PREP: begin
        busy_c    = 1'b1;
        state_nxt = fast ? ST_FINISH : ST_RUN;
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (cnt_q == '0) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        // a start in the done cycle chains straight into the next op
        done_c    = 1'b1;
        state_nxt = bus.start ? ST_PREP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fn_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rd_out_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      neg_main_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (bus.start) begin
            fn_q   <= bus.funct3;
            rd_q   <= bus.rd_in;
            lo_q   <= bus.op_a;
            opnd_q <= bus.op_b;
          end
        end
        ST_PREP: begin
          hi_q       <= '0;
          cnt_q      <= STEP_LAST;
          neg_main_q <= sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
          neg_rem_q  <= sgn_a;
`endif
          // multiply iterates over the multiplier (op_b) bits in lo_q
          if (is_div) begin
            lo_q   <= mag_a;
            opnd_q <= mag_b;
          end else begin
            lo_q   <= mag_b;
            opnd_q <= mag_a;
          end
          if (fast) begin
            result_q <= fast_res;
            rd_out_q <= rd_q;
          end
        end
        ST_RUN: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) begin
            result_q <= fin_res;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
